// File: rtl/insn_fetch_seq.sv
// Fetch/issue sequencer for the RV32I control unit.
// Runs one instruction at a time through FETCH -> DECODE -> EXEC. It latches the
// fetched word, classifies it into a one-hot decoder select, and issues a
// single-cycle commit strobe.
// Optional feature macro: FETCH_TIMEOUT_EN enables the fetch-timeout watchdog
// and the sticky fetch_err flag. Without it, FETCH waits indefinitely.
module insn_fetch_seq #(
  parameter int XLEN          = 32,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ack,
  output logic [XLEN-1:0] insn,
  output logic            insn_valid,
  output logic [8:0]      dec_sel,
  output logic            commit_en,
  output logic            pc_adv,
  output logic            illegal,
  output logic            fetch_err
);

  typedef enum logic [2:0] {RESET_WAIT, FETCH, DECODE, EXEC, TRAP} state_t;

  state_t            state, state_nxt;
  logic [8:0]        dec_sel_nxt;
  logic              timeout_hit;
  logic              addr_held;
  logic [XLEN-1:0]   addr_q;

  // Only the 32-bit datapath and a timeout that fits the 4-bit counter are supported.
  if (XLEN != 32 || FETCH_TIMEOUT < 1 || FETCH_TIMEOUT > 15) begin : g_bad_cfg
    $error("insn_fetch_seq: unsupported XLEN or FETCH_TIMEOUT");
  end

  // One-hot decoder select for a word; all-zero means illegal.
  function automatic logic [8:0] classify(input logic [31:0] w);
    logic [8:0] s;
    s = '0;
    if (w[1:0] == 2'b11) begin
      case (w[6:0])
        7'b0110011: s[0] = 1'b1;
        7'b0010011: s[1] = 1'b1;
        7'b0000011: s[2] = 1'b1;
        7'b1100111: s[3] = (w[14:12] == 3'b000);
        7'b0100011: s[4] = 1'b1;
        7'b1100011: s[5] = 1'b1;
        7'b0110111: s[6] = 1'b1;
        7'b0010111: s[7] = 1'b1;
        7'b1101111: s[8] = 1'b1;
        default:    s    = '0;
      endcase
    end
    return s;
  endfunction

  assign dec_sel_nxt = classify(insn);

  // The first FETCH cycle presents the live PC. That cycle follows the
  // pc_adv edge, so the PC register already holds the new value. The address
  // is then held from addr_q for as long as the memory keeps us waiting.
  assign imem_addr = addr_held ? addr_q : pc;

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] to_cnt;

  assign timeout_hit = (state == FETCH) && !imem_ack &&
                       (to_cnt == 4'(FETCH_TIMEOUT - 1));

  // Count unacknowledged FETCH cycles; zero whenever not waiting in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      to_cnt <= '0;
    else if (state != FETCH || imem_ack)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 4'd1;
  end

  // Sticky fetch-timeout flag; an ack on the terminal cycle suppresses it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fetch_err <= 1'b0;
    else if (timeout_hit)
      fetch_err <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= RESET_WAIT;
    else
      state <= state_nxt;
  end

  // Next-state logic and the combinational request/commit strobes.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    commit_en = 1'b0;
    pc_adv    = 1'b0;
    case (state)
      RESET_WAIT: state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack)
          state_nxt = DECODE;
        else if (timeout_hit)
          state_nxt = TRAP;
      end
      DECODE: state_nxt = (dec_sel_nxt != '0) ? EXEC : TRAP;
      EXEC: begin
        if (!stall) begin
          commit_en = 1'b1;
          pc_adv    = 1'b1;
          state_nxt = FETCH;
        end
      end
      TRAP:    state_nxt = TRAP;
      default: state_nxt = RESET_WAIT;
    endcase
  end

  // Instruction register, held fetch address, decode select and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      insn       <= 32'h0000_0013;
      insn_valid <= 1'b0;
      dec_sel    <= '0;
      illegal    <= 1'b0;
      addr_q     <= '0;
      addr_held  <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            insn      <= imem_rdata;
            addr_held <= 1'b0;
          end else begin
            addr_q    <= imem_addr;
            addr_held <= 1'b1;
          end
        end
        DECODE: begin
          if (dec_sel_nxt != '0) begin
            dec_sel    <= dec_sel_nxt;
            insn_valid <= 1'b1;
          end else begin
            dec_sel <= '0;
            illegal <= 1'b1;
          end
        end
        EXEC: begin
          if (!stall) begin
            dec_sel    <= '0;
            insn_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_insn_fetch_seq.sv
// Directed bench for insn_fetch_seq. Inputs change and outputs are sampled on
// the falling clock edge. Optional macro FETCH_TIMEOUT_EN selects the
// timeout expectations.
module tb_insn_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] insn;
  logic        insn_valid;
  logic [8:0]  dec_sel;
  logic        commit_en;
  logic        pc_adv;
  logic        illegal;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  insn_fetch_seq #(.XLEN(32), .FETCH_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .insn(insn), .insn_valid(insn_valid), .dec_sel(dec_sel),
    .commit_en(commit_en), .pc_adv(pc_adv),
    .illegal(illegal), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, need end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Starts on a FETCH-cycle negedge, zero-wait fetch; returns on the next FETCH negedge.
  task automatic run_insn(input string tag, input logic [31:0] word,
                          input logic [8:0] sel, output int ccyc);
    check({tag, " req"}, 32'(imem_req), 32'd1);
    imem_ack = 1'b1; imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    check({tag, " insn"}, insn, word);
    check({tag, " no commit in decode"}, 32'(commit_en), 32'd0);
    @(negedge clk);
    check({tag, " dec_sel"}, 32'(dec_sel), 32'(sel));
    check({tag, " valid"}, 32'(insn_valid), 32'd1);
    check({tag, " commit"}, 32'(commit_en), 32'd1);
    check({tag, " pc_adv"}, 32'(pc_adv), 32'd1);
    ccyc = cyc;
    @(negedge clk);
    check({tag, " commit one cycle"}, 32'(commit_en), 32'd0);
    check({tag, " sel cleared"}, 32'(dec_sel), 32'd0);
    check({tag, " valid cleared"}, 32'(insn_valid), 32'd0);
  endtask

  // Starts on a FETCH negedge, feeds an illegal word, checks TRAP, resets out.
  task automatic trap_case(input string tag, input logic [31:0] word);
    imem_ack = 1'b1; imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    check({tag, " illegal"}, 32'(illegal), 32'd1);
    check({tag, " sel zero"}, 32'(dec_sel), 32'd0);
    check({tag, " req low"}, 32'(imem_req), 32'd0);
    check({tag, " valid low"}, 32'(insn_valid), 32'd0);
    imem_ack = 1'b1;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0;
    check({tag, " trap holds req"}, 32'(imem_req), 32'd0);
    check({tag, " trap no commit"}, 32'(commit_en), 32'd0);
    check({tag, " trap sticky"}, 32'(illegal), 32'd1);
    rst_n = 1'b0;
    #1;
    check({tag, " reset clears illegal"}, 32'(illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check({tag, " refetch req"}, 32'(imem_req), 32'd1);
  endtask

  initial begin
    int c0, c1, c2;
    rst_n = 1'b0; pc = 32'h0; stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst insn", insn, 32'h0000_0013);
    check("rst dec_sel", 32'(dec_sel), 32'd0);
    check("rst req", 32'(imem_req), 32'd0);
    check("rst commit", 32'(commit_en), 32'd0);
    check("rst pc_adv", 32'(pc_adv), 32'd0);
    check("rst valid", 32'(insn_valid), 32'd0);
    check("rst illegal", 32'(illegal), 32'd0);
    check("rst fetch_err", 32'(fetch_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first fetch addr", imem_addr, 32'h0);

    // jalr x0,0(x1)
    run_insn("jalr", 32'h0000_8067, 9'h008, c0);

    // stall held four EXEC cycles on a NOP
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    @(negedge clk);
    imem_ack = 1'b0; stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall no commit", 32'(commit_en), 32'd0);
      check("stall no pc_adv", 32'(pc_adv), 32'd0);
      check("stall insn held", insn, 32'h0000_0013);
      check("stall sel held", 32'(dec_sel), 32'h002);
    end
    stall = 1'b0;
    #1;
    check("stall release commit", 32'(commit_en), 32'd1);
    @(negedge clk);
    check("stall after commit", 32'(commit_en), 32'd0);
    check("stall back to fetch", 32'(imem_req), 32'd1);

    // back-to-back add, lw, lui
    run_insn("add", 32'h0020_81B3, 9'h001, c0);
    run_insn("lw",  32'h0000_A103, 9'h004, c1);
    run_insn("lui", 32'h1234_50B7, 9'h040, c2);
    check("commit spacing 1", 32'(c1 - c0), 32'd3);
    check("commit spacing 2", 32'(c2 - c1), 32'd3);

    // reset during FETCH, ack lands in the release cycle
    rst_n = 1'b0;
    #1;
    check("midfetch rst req", 32'(imem_req), 32'd0);
    check("midfetch rst insn", insn, 32'h0000_0013);
    @(negedge clk);
    rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0020_81B3;
    @(negedge clk);
    imem_ack = 1'b0;
    check("late ack ignored insn", insn, 32'h0000_0013);
    check("fresh fetch req", 32'(imem_req), 32'd1);
    run_insn("post rst add", 32'h0020_81B3, 9'h001, c0);

    trap_case("jalr f3", 32'h0000_9067);
    trap_case("all ones", 32'hFFFF_FFFF);

    // no ack: address held; timeout behaviour depends on build
    pc = 32'h0000_0100;
    #1;
    check("wait addr first", imem_addr, 32'h0000_0100);
    @(negedge clk);
    pc = 32'h0000_0200;
    #1;
    check("wait addr held", imem_addr, 32'h0000_0100);
`ifdef FETCH_TIMEOUT_EN
    repeat (13) @(negedge clk);
    check("to cycle15 no err", 32'(fetch_err), 32'd0);
    check("to cycle15 req", 32'(imem_req), 32'd1);
    @(negedge clk);
    check("to fetch_err", 32'(fetch_err), 32'd1);
    check("to req dropped", 32'(imem_req), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (14) @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    @(negedge clk);
    imem_ack = 1'b0;
    check("ack on 15 no err", 32'(fetch_err), 32'd0);
    check("ack on 15 insn", insn, 32'h0000_0013);
    @(negedge clk);
    check("ack on 15 commit", 32'(commit_en), 32'd1);
`else
    repeat (99) @(negedge clk);
    check("noack still req", 32'(imem_req), 32'd1);
    check("noack fetch_err", 32'(fetch_err), 32'd0);
    check("noack addr held", imem_addr, 32'h0000_0100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/insn_fetch_seq.md
Name: insn_fetch_seq

Overview:
Fetch/issue sequencer directly upstream of the per-format instruction decoders (R, I-ALU, I-load, I-JALR, S, B, U, J) in the RV32I control unit. Each instruction it:
- requests the word at the current PC from instruction memory;
- latches the word into a stable instruction register;
- classifies the opcode into a one-hot decoder select;
- issues a single-cycle commit strobe, which qualifies register/memory write clocks in the decoders.

Only one instruction is in flight at a time. The block is a multi-cycle state machine, not a pipeline.

Parameters:
XLEN, 32, data/address width; only 32 is supported.
FETCH_TIMEOUT, 15, maximum cycles waiting for imem_ack before a fetch error (used only with the optional feature).

Ports:
clk  in  1  processor clock; all state updates on its rising edge
rst_n  in  1  asynchronous, active-low reset
pc  in  32  current PC from the PC register
stall  in  1  hold EXEC; commit withheld while high
imem_req  out  1  instruction memory request
imem_addr  out  32  fetch address
imem_rdata  in  32  fetched instruction word
imem_ack  in  1  imem_rdata valid this cycle
insn  out  32  latched instruction, stable from DECODE until the next FETCH completes
insn_valid  out  1  insn holds a classified, legal instruction
dec_sel  out  9  one-hot: [0]R [1]I_ALU [2]I_LOAD [3]I_JALR [4]S [5]B [6]LUI [7]AUIPC [8]JAL
commit_en  out  1  one-cycle strobe; decoders gate rd/mem write clocks with it
pc_adv  out  1  one-cycle strobe, coincident with commit_en; PC register loads its next value
illegal  out  1  sticky illegal-instruction flag
fetch_err  out  1  sticky fetch-timeout flag (tied 0 without the optional feature)

Behaviour:
- States: RESET_WAIT, FETCH, DECODE, EXEC, TRAP.
- Reset (asynchronous, any state, including mid-fetch) forces:
  - state RESET_WAIT;
  - insn = 32'h0000_0013 (NOP);
  - dec_sel = 0; all 1-bit outputs 0;
  - timeout counter cleared.
- A late imem_ack arriving after reset deasserts is ignored.
- RESET_WAIT -> FETCH unconditionally after one cycle.
- FETCH:
  - imem_req = 1; imem_addr = pc, registered on FETCH entry and held constant while waiting.
  - On imem_ack: latch insn <= imem_rdata, go to DECODE.
  - A request/ack in the same cycle is allowed, giving a minimum of 1 cycle in FETCH.
- DECODE (1 cycle): classify insn[6:0]:
  - 0110011 R; 0010011 I_ALU; 0000011 I_LOAD; 1100111 I_JALR; 0100011 S; 1100011 B; 0110111 LUI; 0010111 AUIPC; 1101111 JAL.
  - Illegal if any of: insn[1:0] != 2'b11; opcode unlisted; JALR with funct3 != 000.
  - Legal: dec_sel registered, insn_valid = 1, go to EXEC.
  - Illegal: illegal = 1, dec_sel = 0, go to TRAP.
- EXEC:
  - If stall = 0: commit_en = pc_adv = 1 for exactly this cycle, then FETCH.
  - If stall = 1: remain in EXEC, no strobes, insn/dec_sel held. Commit happens in the first cycle after stall falls.
- insn_valid and dec_sel stay valid from DECODE exit through EXEC; both clear on FETCH entry.
- Minimum latency per instruction: 3 cycles (FETCH, DECODE, EXEC) with zero-wait memory.
- TRAP: absorbing; imem_req = 0, no strobes; exit only via rst_n.
- stall is ignored outside EXEC.
- imem_ack is ignored outside FETCH.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A 4-bit counter clears on FETCH entry and increments each FETCH cycle without ack.
  - When the count reaches FETCH_TIMEOUT with no ack: fetch_err = 1, imem_req drops, state goes to TRAP.
  - An ack in the same cycle as the terminal count wins: no error.
- Undefined:
  - FETCH waits indefinitely.
  - fetch_err is constant 0; no counter logic is present.

Test Plan:
- Reset, then pc=32'h0000_0000, imem_rdata=32'h0000_8067 (jalr x0,0(x1)), ack after 0 waits -> dec_sel=9'b000001000, commit_en high exactly cycle 3 after FETCH entry, insn=32'h0000_8067.
- Sequence add (32'h0020_81B3), lw (32'h0000_A103), lui (32'h1234_50B7) -> dec_sel 001h, 004h, 040h; three commit pulses, 3 cycles apart.
- stall=1 for 4 cycles in EXEC with insn=32'h0000_0013 -> no commit during stall; single commit on the cycle after stall falls; insn held constant throughout.
- JALR with funct3=001 (32'h0000_9067), and separately imem_rdata=32'hFFFF_FFFF -> illegal=1, dec_sel=0, imem_req stays 0; recovers only after rst_n pulse.
- rst_n asserted while in FETCH with imem_req=1, ack arriving in the cycle rst_n releases -> ack ignored, insn=32'h0000_0013, fresh fetch begins after RESET_WAIT.
- With FETCH_TIMEOUT_EN, FETCH_TIMEOUT=15, never ack -> fetch_err=1 after 15 FETCH cycles. Ack on cycle 15 -> no error, normal DECODE. Without the macro, 100 cycles without ack -> still in FETCH, fetch_err=0.
